// File: rtl/dtpu_pkg.sv
// dtpu_pkg: shared DTPU datapath constants and helpers
package dtpu_pkg;

    localparam int DTPU_DATA_W = 8;

    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one elastic pipeline slot, a data register plus its valid bit
module pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scan,
    input  logic             clear,
    input  logic             load,
    input  logic             v_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             v,
    output logic [WIDTH-1:0] data
);

    // bubbles advance the valid bit but leave the data register untouched
    always_ff @(posedge clk) begin
        if (!reset) begin
            v    <= 1'b0;
            data <= '0;
        end else if (scan) begin
            v    <= 1'b0;
            data <= d_in;
        end else if (clear) begin
            v <= 1'b0;
        end else if (load) begin
            v <= v_in;
            if (v_in) data <= d_in;
        end
    end

endmodule

// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: collapsing valid/ready register pipeline with scan shift and flush
module elastic_pipe_reg
    import dtpu_pkg::*;
#(
    parameter int WIDTH = DTPU_DATA_W,
    parameter int DEPTH = 4,
    localparam int CW = count_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             test_mode,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic [WIDTH-1:0] scan_in,
    output logic [WIDTH-1:0] scan_out,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0] v, mov, v_src;
    logic [WIDTH-1:0] data  [DEPTH];
    logic [WIDTH-1:0] d_src [DEPTH];
    logic [CW-1:0]    cnt;
    logic             acc, emit;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        // stage i can load when it or any stage downstream of it has a hole, or the tail drains
        assign mov[i] = !(&v[DEPTH-1:i]) | out_ready;
        if (i == 0) begin : g_head
            assign v_src[i] = in_valid;
            assign d_src[i] = test_mode ? scan_in : in_data;
        end else begin : g_body
            assign v_src[i] = v[i-1];
            assign d_src[i] = data[i-1];
        end
        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk   (clk),
            .reset (reset),
            .scan  (test_mode),
            .clear (flush),
            .load  (mov[i]),
            .v_in  (v_src[i]),
            .d_in  (d_src[i]),
            .v     (v[i]),
            .data  (data[i])
        );
    end

    assign in_ready  = !test_mode & mov[0];
    assign out_valid = !test_mode & v[DEPTH-1];
    assign out_data  = data[DEPTH-1];
    assign scan_out  = data[DEPTH-1];
    assign acc       = in_valid & in_ready;
    assign emit      = out_valid & out_ready;
    assign count     = cnt;

    always_ff @(posedge clk) begin
        if (!reset || test_mode || flush) cnt <= '0;
        else cnt <= cnt + CW'(acc) - CW'(emit);
    end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// tb_elastic_pipe_reg: randomized scoreboard bench against a word-position reference model
module tb_elastic_pipe_reg;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset, test_mode, flush, in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] in_data, out_data, scan_in, scan_out;
    logic [2:0]       count;

    elastic_pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .test_mode (test_mode),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .scan_in   (scan_in),
        .scan_out  (scan_out),
        .count     (count)
    );

    always #5 clk = ~clk;

    // reference model: words in flight (oldest first) with their stage position
    logic [WIDTH-1:0] qd [$];
    int               qp [$];
    logic [WIDTH-1:0] sh [DEPTH];
    int               nt = 0;
    bit               zero_data = 1'b1;
    bit               l_ir = 1'b1;
    bit               chk_en = 1'b0;
    int               n_cmp = 0;
    int               n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // monitor: mid-cycle sampling, pops the scoreboard on every output handshake
    always @(negedge clk) begin
        bit ov, ir;
        ov   = !test_mode && qd.size() > 0 && qp[0] == DEPTH - 1;
        ir   = !test_mode && (qd.size() < DEPTH || out_ready);
        l_ir = ir;
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(ov));
            chk("in_ready", 32'(in_ready), 32'(ir));
            chk("count", 32'(count), 32'(qd.size()));
            chk("scan_out_eq", 32'(scan_out), 32'(out_data));
            if (zero_data) chk("out_data_zero", 32'(out_data), 32'h0);
            if (nt >= DEPTH) chk("scan_shift", 32'(scan_out), 32'(sh[DEPTH-1]));
            if (ov && out_ready) begin
                chk("out_data", 32'(out_data), 32'(qd[0]));
                void'(qd.pop_front());
                void'(qp.pop_front());
            end
        end
    end

    // model update at each rising edge: words advance one stage unless blocked by the word ahead
    always @(posedge clk) begin
        if (!reset) begin
            qd.delete();
            qp.delete();
            zero_data = 1'b1;
            nt = 0;
        end else if (test_mode) begin
            for (int j = DEPTH - 1; j > 0; j--) sh[j] = sh[j-1];
            sh[0] = scan_in;
            nt++;
            qd.delete();
            qp.delete();
            zero_data = 1'b0;
        end else begin
            nt = 0;
            if (flush) begin
                qd.delete();
                qp.delete();
            end else begin
                int lim;
                lim = DEPTH;
                for (int j = 0; j < qp.size(); j++) begin
                    qp[j] = (qp[j] + 1 < lim - 1) ? qp[j] + 1 : lim - 1;
                    lim = qp[j];
                end
                if (in_valid && l_ir) begin
                    qd.push_back(in_data);
                    qp.push_back(0);
                end
                for (int j = 0; j < qp.size(); j++) if (qp[j] == DEPTH - 1) zero_data = 1'b0;
            end
        end
    end

    task automatic drive(input bit iv, input logic [WIDTH-1:0] d, input bit ordy, input bit fl, input bit tm);
        in_valid  = iv;
        in_data   = d;
        scan_in   = d;
        out_ready = ordy;
        flush     = fl;
        test_mode = tm;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'($urandom), 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        test_mode = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = '0;
        scan_in = '0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b1;
        chk_en = 1'b1;
        // streaming at full rate
        for (int i = 1; i <= 16; i++) drive(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
        idle(DEPTH + 2);
        // fill against a stall, then release
        repeat (6) drive(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        repeat (3) drive(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
        idle(DEPTH + 2);
        // bubbles collapse behind a stall
        for (int i = 0; i < 8; i++) drive(i % 2 == 0, 8'($urandom), 1'b0, 1'b0, 1'b0);
        idle(DEPTH + 2);
        // scan shift over a partly filled pipe
        repeat (3) drive(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        idle(3);
        // flush at count 3 together with an output handshake
        repeat (3) drive(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        repeat (4) drive(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'($urandom), 1'b1, 1'b1, 1'b0);
        idle(3);
        // reset mid-stream at count 2
        repeat (2) drive(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        drive(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        idle(3);
        // randomized traffic with varying back-pressure
        for (int k = 0; k < 3000; k++) begin
            int mode;
            bit ordy;
            mode = (k / 50) % 3;
            ordy = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 299) != 0);
            drive($urandom_range(0, 3) != 0, 8'($urandom), ordy,
                  $urandom_range(0, 59) == 0, $urandom_range(0, 99) == 0);
            reset = 1'b1;
        end
        idle(DEPTH + 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/elastic_pipe_reg.md
# elastic_pipe_reg

Parametrised elastic register pipeline: WIDTH-bit data, DEPTH stages, each stage a data register plus a valid bit, with a valid/ready handshake on both ends. Empty stages collapse, so a downstream stall fills the pipe before it back-pressures. Used between DTPU datapath units as the general-purpose replacement for the single-stage enabled register. Carries a scan-shift test mode and a synchronous flush.

## Interface
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 4, number of stages (>=1)
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-low
- test_mode  in  1  1 = scan-shift mode, handshakes disabled
- flush  in  1  synchronous clear of all valid bits
- in_valid  in  1  upstream data valid
- in_ready  out  1  pipe accepts in_data this cycle
- in_data  in  WIDTH  upstream data
- out_valid  out  1  last stage holds valid data
- out_ready  in  1  downstream accepts out_data this cycle
- out_data  out  WIDTH  last-stage data register
- scan_in  in  WIDTH  test-mode shift input to stage 0
- scan_out  out  WIDTH  last-stage data; identical to out_data
- count  out  CW  number of valid stages, 0..DEPTH; CW = clog2(DEPTH+1)

## Operation
- State: per stage i, data[i] (WIDTH) and v[i] (1); stage 0 is input side, stage DEPTH-1 is output side.
- Reset (reset==0 at a rising edge): all data[i] = 0, all v[i] = 0. Outputs after reset: out_valid 0, out_data/scan_out 0, count 0, in_ready 1 (0 if test_mode).
- Priority at each edge: reset > test_mode > flush > normal.
- Normal mode:
  - adv[DEPTH-1] = v[DEPTH-1] & out_ready.
  - mov[i] = !v[i] | adv[i], meaning stage i can load.
  - adv[i] = v[i] & mov[i+1] for i < DEPTH-1.
  - in_ready = mov[0].
  - Stage i with mov[i] loads from stage i-1: data <= data[i-1], v <= v[i-1] (stage 0 loads in_data and in_valid).
  - A stage that does not move holds.
  - data registers update only when the incoming v is 1; bubbles do not overwrite data.
- Ready is a combinational chain from out_ready to in_ready.
- No combinational path from in_valid or in_data to any output.
- flush: all v <= 0; data unchanged; input offered in that cycle is dropped.
- Flush in the same cycle as an output handshake: the output transfer counts; that stage is still cleared.
- test_mode:
  - Unconditional shift: data[0] <= scan_in, data[i] <= data[i-1].
  - All v <= 0.
  - in_ready = 0 and out_valid = 0, combinationally while test_mode = 1.
  - Leaving test_mode gives an empty pipe with scanned data retained but invalid.
- count = popcount of v, registered alongside v.
  - +1 on accept without emit, -1 on emit without accept, unchanged on both or neither.
  - 0 after flush, test_mode or reset.

## Timing
- Latency: a word accepted at edge k into an empty pipe drives out_valid in the cycle after edge k+DEPTH-1, i.e. DEPTH cycles.
- Throughput: 1 word/cycle while out_ready = 1, including at full occupancy.
  - At full occupancy in_ready follows out_ready in the same cycle.
- Full (count==DEPTH) with out_ready=0: in_ready=0, all stages hold.
- Empty: out_valid=0. out_ready is ignored.
- Reset asserted mid-transfer: in-flight words are lost. in_ready=1 from the first cycle after the reset edge.
- DEPTH=1: in_ready = !v[0] | out_ready; latency 1.

## Structure
- Shared package dtpu_pkg holds a clog2-based count-width function and a default DTPU_DATA_W constant.
- One sub-module, pipe_stage, generated DEPTH times.
  - pipe_stage holds one data register plus one valid bit, with load/hold/clear controls.
  - The top level computes the mov/adv chain, test-mode muxing and count.

## Test plan
- Reset, then stream 0x01..0x10, in_valid=1, out_ready=1, DEPTH=4 -> first out at cycle 4, then one word/cycle in order; count steady at 4.
- Fill 4 words with out_ready=0 -> count=4, in_ready=0 on the 5th offer; release out_ready -> in_ready=1 in the same cycle, order preserved.
- Alternate in_valid 1/0 with out_ready=0 for 8 cycles -> bubbles collapse, 4 words held contiguously, count=4.
- test_mode=1, scan_in=0xA5,0x5A,0xFF,0x00 -> scan_out=0xA5 after the 4th edge; out_valid and in_ready stay 0; count=0 after exit.
- Flush at count=3 together with an out handshake -> the output word is delivered, count=0 next cycle, the word offered that cycle is dropped.
- reset=0 mid-stream at count=2 -> the next cycle shows out_valid=0, out_data=0, count=0, in_ready=1.
